// File: rtl/attention_e_buf_rsp.sv
// TxT exp-score buffer with a fixed-latency read responder.
// Per-entry written flags drive the fill count and the read-error path.
module attention_e_buf_rsp #(
   parameter  int T            = 8,
   parameter  int DATA_W       = 32,
   parameter  int RD_LAT       = 1,
   parameter  int CONFLICT_POL = 1,
   localparam int T_W          = $clog2(T),
   localparam int CNT_W        = $clog2(T*T+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [T_W-1:0]    wr_tq,
   input  logic [T_W-1:0]    wr_tk,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              e_re,
   input  logic [T_W-1:0]    e_tq,
   input  logic [T_W-1:0]    e_tk,
   output logic [DATA_W-1:0] e_rdata,
   output logic              e_rvalid,
   output logic              e_rerr,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic              full
);

   localparam int N  = T * T;
   localparam int AW = $clog2(N);
   localparam logic [T_W:0]    W_T = (T_W+1)'(T);
   localparam logic [AW-1:0]   A_T = AW'(T);
   localparam logic [CNT_W-1:0] C_N = CNT_W'(N);

   function automatic logic [AW-1:0] f_addr(
      input logic [T_W-1:0] q,
      input logic [T_W-1:0] k
   );
      return AW'(q) * A_T + AW'(k);
   endfunction

   logic [DATA_W-1:0] r_mem [N];
   logic [N-1:0]      r_flag;
   logic [CNT_W-1:0]  r_cnt;

   logic [RD_LAT-1:0] r_pv;
   logic [RD_LAT-1:0] r_pe;
   logic [DATA_W-1:0] r_pd [RD_LAT];

   logic              w_wr_ok;
   logic              w_rd_ok;
   logic [AW-1:0]     w_wr_a;
   logic [AW-1:0]     w_rd_a;
   logic              w_wr_go;
   logic              w_hit;
   logic              w_old_f;
   logic [DATA_W-1:0] w_old_d;
   logic              w_smp_f;
   logic [DATA_W-1:0] w_smp_d;

   // Non-power-of-two T leaves unused index codes; those are rejected.
   assign w_wr_ok = ({1'b0, wr_tq} < W_T) && ({1'b0, wr_tk} < W_T);
   assign w_rd_ok = ({1'b0, e_tq} < W_T) && ({1'b0, e_tk} < W_T);
   assign w_wr_a  = f_addr(wr_tq, wr_tk);
   assign w_rd_a  = f_addr(e_tq, e_tk);
   assign w_wr_go = wr_en & w_wr_ok;
   assign w_hit   = w_wr_go & e_re & w_rd_ok & (w_wr_a == w_rd_a);

   always_comb begin
      w_old_f = 1'b0;
      w_old_d = '0;
      if (w_rd_ok) begin
         w_old_f = r_flag[w_rd_a];
         w_old_d = r_mem[w_rd_a];
      end
   end

   // Never-written entries always return zero data.
   always_comb begin
      w_smp_f = w_old_f;
      w_smp_d = w_old_d;
      if ((CONFLICT_POL != 0) && w_hit) begin
         w_smp_f = 1'b1;
         w_smp_d = wr_data;
      end
      if (!w_smp_f) begin
         w_smp_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_go) begin
         r_mem[w_wr_a] <= wr_data;
      end
   end

   // A write in the clear cycle lands after the clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flag <= '0;
         r_cnt  <= '0;
      end else begin
         if (clr) begin
            r_flag <= '0;
            r_cnt  <= '0;
         end
         if (w_wr_go) begin
            r_flag[w_wr_a] <= 1'b1;
            if (clr) begin
               r_cnt <= CNT_W'(1);
            end else if (!r_flag[w_wr_a]) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Data stages only advance behind a valid so the tail holds its value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pv <= '0;
         r_pe <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_pd[i] <= '0;
         end
      end else begin
         r_pv[0] <= e_re;
         r_pe[0] <= e_re & ~w_smp_f;
         if (e_re) begin
            r_pd[0] <= w_smp_d;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pe[i] <= r_pe[i-1];
            if (r_pv[i-1]) begin
               r_pd[i] <= r_pd[i-1];
            end
         end
      end
   end

   assign e_rvalid = r_pv[RD_LAT-1];
   assign e_rerr   = r_pe[RD_LAT-1];
   assign e_rdata  = r_pd[RD_LAT-1];
   assign wr_cnt   = r_cnt;
   assign full     = (r_cnt == C_N);

endmodule
